// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, load FSM state type and index helpers for the matrix store
package matrix_pkg;

  localparam int MAX_DIM = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } load_state_e;

  // A dimension pair is usable only when both sides lie in 1..max_dim.
  function automatic logic dims_in_range(input logic [3:0] m, input logic [3:0] n,
                                         input int max_dim);
    return (m != 4'd0) && (int'(m) <= max_dim) && (n != 4'd0) && (int'(n) <= max_dim);
  endfunction

  function automatic int combo_index(input logic [3:0] m, input logic [3:0] n,
                                     input int max_dim);
    return (int'(m) - 1) * max_dim + (int'(n) - 1);
  endfunction

  // Flat element address; also used by the operation FSM to walk stored operands.
  function automatic int compose_addr(input int combo, input int slot, input int row,
                                      input int col, input int slots, input int max_dim);
    return ((combo * slots + slot) * max_dim + row) * max_dim + col;
  endfunction

endpackage

// File: rtl/matrix_slot_alloc.sv
// rtl/matrix_slot_alloc.sv - per-combo slot valid bits, FIFO replacement pointers and slot allocation
//   clk, rst                      : clock, async active-high reset
//   alloc_en/alloc_combo          : claim a slot (invalidates it); alloc_slot is the combinational choice
//   commit_en/commit_combo/_slot  : mark a fully loaded slot valid
//   clr_one_en/clr_combo/clr_slot : invalidate one slot, pointer untouched
//   clr_all                       : invalidate everything and rewind all pointers
//   query_en/query_combo          : query_mask/query_count of one combo (mask 0 when !query_en)
//   chk_combo/chk_slot            : chk_valid, the valid bit used by the read path
module matrix_slot_alloc #(
  parameter int NUM_COMBOS = 25,
  parameter int SLOTS      = 2,
  parameter int SLOT_BITS  = 1,
  parameter int COMBO_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_en,
  input  logic [COMBO_BITS-1:0] alloc_combo,
  output logic [SLOT_BITS-1:0]  alloc_slot,
  input  logic                  commit_en,
  input  logic [COMBO_BITS-1:0] commit_combo,
  input  logic [SLOT_BITS-1:0]  commit_slot,
  input  logic                  clr_one_en,
  input  logic [COMBO_BITS-1:0] clr_combo,
  input  logic [SLOT_BITS-1:0]  clr_slot,
  input  logic                  clr_all,
  input  logic                  query_en,
  input  logic [COMBO_BITS-1:0] query_combo,
  output logic [SLOTS-1:0]      query_mask,
  output logic [SLOT_BITS:0]    query_count,
  input  logic [COMBO_BITS-1:0] chk_combo,
  input  logic [SLOT_BITS-1:0]  chk_slot,
  output logic                  chk_valid
);
  import matrix_pkg::*;

  logic [SLOTS-1:0]     valid_q [NUM_COMBOS];
  logic [SLOT_BITS-1:0] ptr_q   [NUM_COMBOS];

  logic                 alloc_has_free;
  logic [SLOT_BITS-1:0] free_slot;
  logic [SLOT_BITS-1:0] ptr_next;

  // Scan downwards so the lowest-index free slot is the one left standing.
  always_comb begin
    alloc_has_free = 1'b0;
    free_slot      = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (!valid_q[alloc_combo][s]) begin
        alloc_has_free = 1'b1;
        free_slot      = SLOT_BITS'(s);
      end
    end
  end

  assign ptr_next   = (ptr_q[alloc_combo] == SLOT_BITS'(SLOTS - 1)) ? '0
                                                                      : ptr_q[alloc_combo] + 1'b1;
  assign alloc_slot = alloc_has_free ? free_slot : ptr_q[alloc_combo];

  always_comb begin
    query_mask  = query_en ? valid_q[query_combo] : '0;
    query_count = '0;
    for (int s = 0; s < SLOTS; s++) begin
      query_count = query_count + (SLOT_BITS + 1)'(query_mask[s]);
    end
  end

  assign chk_valid = valid_q[chk_combo][chk_slot];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_COMBOS; c++) begin
        valid_q[c] <= '0;
        ptr_q[c]   <= '0;
      end
    end else if (clr_all) begin
      for (int c = 0; c < NUM_COMBOS; c++) begin
        valid_q[c] <= '0;
        ptr_q[c]   <= '0;
      end
    end else begin
      if (alloc_en) begin
        valid_q[alloc_combo][alloc_slot] <= 1'b0;
        // The FIFO pointer only moves when an occupied slot is evicted.
        if (!alloc_has_free) ptr_q[alloc_combo] <= ptr_next;
      end
      if (commit_en)  valid_q[commit_combo][commit_slot] <= 1'b1;
      if (clr_one_en) valid_q[clr_combo][clr_slot] <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_bank.sv
// rtl/matrix_bank.sv - slot-based matrix store between the UART input parser and the operation FSM
//   clk, rst                         : clock, async active-high reset
//   wr_start, wr_m, wr_n, wr_abort   : begin / abandon a row-major load of a wr_m x wr_n matrix
//   elem_in, elem_valid, elem_ready  : element stream handshake
//   wr_busy, wr_done, wr_err, wr_slot: load status, commit pulse, reject pulse, allocated slot
//   rd_req, rd_m, rd_n, rd_slot,
//   rd_row, rd_col                   : element read request (1-cycle latency)
//   rd_data, rd_valid, rd_hit        : read response; rd_data is 0 unless rd_hit
//   query_m, query_n                 : combinational query_mask / query_count of a combo
//   clr_one                          : clear slot rd_slot of combo (query_m, query_n)
//   clr_all                          : clear every slot and abort any load
module matrix_bank #(
  parameter int MAX_DIM       = matrix_pkg::MAX_DIM,
  parameter int SLOTS_PER_DIM = 2,
  parameter int ELEM_WIDTH    = 8,
  parameter int DIM_BITS      = 3,
  parameter int SLOT_BITS     = $clog2(SLOTS_PER_DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_start,
  input  logic [3:0]            wr_m,
  input  logic [3:0]            wr_n,
  input  logic                  wr_abort,
  input  logic [ELEM_WIDTH-1:0] elem_in,
  input  logic                  elem_valid,
  output logic                  elem_ready,
  output logic                  wr_busy,
  output logic                  wr_done,
  output logic                  wr_err,
  output logic [SLOT_BITS-1:0]  wr_slot,
  input  logic                  rd_req,
  input  logic [3:0]            rd_m,
  input  logic [3:0]            rd_n,
  input  logic [SLOT_BITS-1:0]  rd_slot,
  input  logic [DIM_BITS-1:0]   rd_row,
  input  logic [DIM_BITS-1:0]   rd_col,
  output logic [ELEM_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_hit,
  input  logic [3:0]            query_m,
  input  logic [3:0]            query_n,
  output logic [SLOTS_PER_DIM-1:0] query_mask,
  output logic [SLOT_BITS:0]    query_count,
  input  logic                  clr_one,
  input  logic                  clr_all
);
  import matrix_pkg::*;

  localparam int NUM_COMBOS = MAX_DIM * MAX_DIM;
  localparam int COMBO_BITS = $clog2(NUM_COMBOS);
  localparam int DEPTH      = SLOTS_PER_DIM * NUM_COMBOS * MAX_DIM * MAX_DIM;
  localparam int ADDR_BITS  = $clog2(DEPTH);

  load_state_e state_q, state_d;

  logic [COMBO_BITS-1:0] ld_combo_q;
  logic [SLOT_BITS-1:0]  ld_slot_q;
  logic [3:0]            ld_m_q, ld_n_q;
  logic [DIM_BITS-1:0]   row_q, col_q;
  logic                  wr_done_q, wr_err_q;
  logic                  rd_valid_q, rd_hit_q;
  logic [ELEM_WIDTH-1:0] rd_mem_q;

  logic [ELEM_WIDTH-1:0] mem [DEPTH];

  // ---------------- load control ----------------
  logic                  wr_dims_ok, start_ok, alloc_en, start_bad;
  logic                  beat, last_row, last_col, last_beat;
  logic [COMBO_BITS-1:0] wr_combo;
  logic [SLOT_BITS-1:0]  alloc_slot;
  logic [ADDR_BITS-1:0]  wr_addr;

  assign wr_dims_ok = dims_in_range(wr_m, wr_n, MAX_DIM);
  assign wr_combo   = wr_dims_ok ? COMBO_BITS'(combo_index(wr_m, wr_n, MAX_DIM)) : '0;
  // clr_all swallows a same-cycle start entirely, including its error pulse.
  assign start_ok   = (state_q == ST_IDLE) && wr_start && !clr_all;
  assign alloc_en   = start_ok && wr_dims_ok;
  assign start_bad  = start_ok && !wr_dims_ok;

  // A beat coinciding with clr_all or wr_abort is dropped.
  assign beat      = (state_q == ST_LOAD) && elem_valid && !clr_all && !wr_abort;
  assign last_col  = (4'(col_q) == ld_n_q - 4'd1);
  assign last_row  = (4'(row_q) == ld_m_q - 4'd1);
  assign last_beat = beat && last_row && last_col;

  assign wr_addr = ADDR_BITS'(compose_addr(int'(ld_combo_q), int'(ld_slot_q), int'(row_q),
                                           int'(col_q), SLOTS_PER_DIM, MAX_DIM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (alloc_en) state_d = ST_LOAD;
      ST_LOAD: if (clr_all || wr_abort || last_beat) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    elem_ready = 1'b0;
    wr_busy    = 1'b0;
    if (state_q == ST_LOAD) begin
      elem_ready = 1'b1;
      wr_busy    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_combo_q <= '0;
      ld_slot_q  <= '0;
      ld_m_q     <= '0;
      ld_n_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_done_q <= last_beat;
      wr_err_q  <= start_bad;
      if (alloc_en) begin
        ld_combo_q <= wr_combo;
        ld_slot_q  <= alloc_slot;
        ld_m_q     <= wr_m;
        ld_n_q     <= wr_n;
        row_q      <= '0;
        col_q      <= '0;
      end else if (beat) begin
        // Row/col counters replace a cnt / n divider.
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign wr_done = wr_done_q;
  assign wr_err  = wr_err_q;
  assign wr_slot = ld_slot_q;

  // ---------------- read path ----------------
  logic                  rd_dims_ok, rd_in_range, chk_valid, rd_hit_d;
  logic [COMBO_BITS-1:0] rd_combo;
  logic [ADDR_BITS-1:0]  rd_addr;

  assign rd_dims_ok  = dims_in_range(rd_m, rd_n, MAX_DIM);
  assign rd_combo    = rd_dims_ok ? COMBO_BITS'(combo_index(rd_m, rd_n, MAX_DIM)) : '0;
  assign rd_in_range = rd_dims_ok && (4'(rd_row) < rd_m) && (4'(rd_col) < rd_n) &&
                       (int'(rd_slot) < SLOTS_PER_DIM);
  assign rd_addr     = rd_in_range ? ADDR_BITS'(compose_addr(int'(rd_combo), int'(rd_slot),
                                     int'(rd_row), int'(rd_col), SLOTS_PER_DIM, MAX_DIM))
                                   : '0;
  assign rd_hit_d    = rd_req && rd_in_range && chk_valid;

  // Contents are not reset; a slot is only readable after a complete load rewrote it.
  always_ff @(posedge clk) begin
    if (beat)   mem[wr_addr] <= elem_in;
    if (rd_req) rd_mem_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      rd_hit_q   <= rd_hit_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_hit   = rd_hit_q;
  assign rd_data  = rd_hit_q ? rd_mem_q : '0;

  // ---------------- query / clear ----------------
  logic                  query_ok, clr_one_en;
  logic [COMBO_BITS-1:0] query_combo;

  assign query_ok    = dims_in_range(query_m, query_n, MAX_DIM);
  assign query_combo = query_ok ? COMBO_BITS'(combo_index(query_m, query_n, MAX_DIM)) : '0;
  // The slot currently being filled is protected; it only becomes valid on commit anyway.
  assign clr_one_en  = clr_one && query_ok && (int'(rd_slot) < SLOTS_PER_DIM) &&
                       !((state_q == ST_LOAD) && (query_combo == ld_combo_q) &&
                         (rd_slot == ld_slot_q));

  matrix_slot_alloc #(
    .NUM_COMBOS (NUM_COMBOS),
    .SLOTS      (SLOTS_PER_DIM),
    .SLOT_BITS  (SLOT_BITS),
    .COMBO_BITS (COMBO_BITS)
  ) u_slot_alloc (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc_en),
    .alloc_combo  (wr_combo),
    .alloc_slot   (alloc_slot),
    .commit_en    (last_beat),
    .commit_combo (ld_combo_q),
    .commit_slot  (ld_slot_q),
    .clr_one_en   (clr_one_en),
    .clr_combo    (query_combo),
    .clr_slot     (rd_slot),
    .clr_all      (clr_all),
    .query_en     (query_ok),
    .query_combo  (query_combo),
    .query_mask   (query_mask),
    .query_count  (query_count),
    .chk_combo    (rd_combo),
    .chk_slot     (rd_slot),
    .chk_valid    (chk_valid)
  );

endmodule

// File: tb/tb_matrix_bank.sv
// tb/tb_matrix_bank.sv - self-checking bench for matrix_bank against a behavioural slot/matrix model
module tb_matrix_bank;
  localparam int MD = 5;
  localparam int SL = 2;
  localparam int EW = 8;
  localparam int DB = 3;
  localparam int SB = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_start, wr_abort, elem_valid, rd_req, clr_one, clr_all;
  logic [3:0]    wr_m, wr_n, rd_m, rd_n, query_m, query_n;
  logic [EW-1:0] elem_in;
  logic [SB-1:0] rd_slot;
  logic [DB-1:0] rd_row, rd_col;
  logic          elem_ready, wr_busy, wr_done, wr_err, rd_valid, rd_hit;
  logic [SB-1:0] wr_slot;
  logic [EW-1:0] rd_data;
  logic [SL-1:0] query_mask;
  logic [SB:0]   query_count;

  matrix_bank #(.MAX_DIM(MD), .SLOTS_PER_DIM(SL), .ELEM_WIDTH(EW), .DIM_BITS(DB)) dut (
    .clk(clk), .rst(rst), .wr_start(wr_start), .wr_m(wr_m), .wr_n(wr_n), .wr_abort(wr_abort),
    .elem_in(elem_in), .elem_valid(elem_valid), .elem_ready(elem_ready), .wr_busy(wr_busy),
    .wr_done(wr_done), .wr_err(wr_err), .wr_slot(wr_slot), .rd_req(rd_req), .rd_m(rd_m),
    .rd_n(rd_n), .rd_slot(rd_slot), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .query_m(query_m), .query_n(query_n),
    .query_mask(query_mask), .query_count(query_count), .clr_one(clr_one), .clr_all(clr_all)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: each stored matrix is a row-major list of elements per (m, n, slot).
  bit            mvalid [1:MD][1:MD][0:SL-1];
  int            mptr   [1:MD][1:MD];
  logic [EW-1:0] mdata  [1:MD][1:MD][0:SL-1][0:MD*MD-1];

  function automatic bit dims_ok(input int m, input int n);
    return (m >= 1) && (m <= MD) && (n >= 1) && (n <= MD);
  endfunction

  function automatic void model_clear_all();
    for (int i = 1; i <= MD; i++)
      for (int j = 1; j <= MD; j++) begin
        mptr[i][j] = 0;
        for (int s = 0; s < SL; s++) mvalid[i][j][s] = 1'b0;
      end
  endfunction

  // Free slot first (lowest index), otherwise evict the oldest in round-robin order.
  function automatic int model_alloc(input int m, input int n);
    int s;
    for (int k = 0; k < SL; k++)
      if (!mvalid[m][n][k]) return k;
    s = mptr[m][n];
    mptr[m][n] = (s + 1) % SL;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic query_check(input int m, input int n);
    logic [SL-1:0] exp_mask;
    int cnt;
    query_m = 4'(m);
    query_n = 4'(n);
    #1;
    exp_mask = '0;
    cnt = 0;
    if (dims_ok(m, n))
      for (int s = 0; s < SL; s++)
        if (mvalid[m][n][s]) begin
          exp_mask[s] = 1'b1;
          cnt++;
        end
    check("query_mask", 32'(query_mask), 32'(exp_mask));
    check("query_count", 32'(query_count), cnt);
  endtask

  function automatic logic [EW-1:0] model_read(input int m, input int n, input int slot,
                                               input int row, input int col, output bit hit);
    hit = 1'b0;
    if (dims_ok(m, n))
      if (mvalid[m][n][slot] && row < m && col < n) hit = 1'b1;
    return hit ? mdata[m][n][slot][row * n + col] : '0;
  endfunction

  task automatic set_read(input int m, input int n, input int slot, input int row, input int col);
    rd_req = 1'b1;
    rd_m = 4'(m);
    rd_n = 4'(n);
    rd_slot = SB'(slot);
    rd_row = DB'(row);
    rd_col = DB'(col);
  endtask

  task automatic read_check(input int m, input int n, input int slot, input int row, input int col);
    bit hit;
    logic [EW-1:0] d;
    d = model_read(m, n, slot, row, col, hit);
    set_read(m, n, slot, row, col);
    tick();
    rd_req = 1'b0;
    check("rd_valid", 32'(rd_valid), 1);
    check("rd_hit", 32'(rd_hit), 32'(hit));
    check("rd_data", 32'(rd_data), 32'(d));
  endtask

  // fill: -1 random, -2 sequential 1..m*n, otherwise a constant. abort_at: beat index to abort at, -1 none.
  task automatic do_load(input int m, input int n, input int abort_at, input int fill);
    int slot;
    int nb;
    logic [EW-1:0] v;
    nb = m * n;
    slot = model_alloc(m, n);
    mvalid[m][n][slot] = 1'b0;
    wr_start = 1'b1;
    wr_m = 4'(m);
    wr_n = 4'(n);
    tick();
    wr_start = 1'b0;
    check("busy_after_start", 32'(wr_busy), 1);
    check("ready_after_start", 32'(elem_ready), 1);
    check("wr_slot", 32'(wr_slot), slot);
    for (int k = 0; k < nb; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        elem_valid = 1'b0;
        tick();
      end
      if (k == abort_at) begin
        wr_abort = 1'b1;
        elem_valid = 1'b1;
        elem_in = EW'($urandom);
        tick();
        wr_abort = 1'b0;
        elem_valid = 1'b0;
        check("abort_busy", 32'(wr_busy), 0);
        check("abort_no_done", 32'(wr_done), 0);
        return;
      end
      if (fill == -1)      v = EW'($urandom);
      else if (fill == -2) v = EW'(k + 1);
      else                 v = EW'(fill);
      mdata[m][n][slot][k] = v;
      elem_valid = 1'b1;
      elem_in = v;
      tick();
    end
    elem_valid = 1'b0;
    mvalid[m][n][slot] = 1'b1;
    check("wr_done", 32'(wr_done), 1);
    check("ready_after_last", 32'(elem_ready), 0);
    query_check(m, n);
    tick();
    check("done_pulse_end", 32'(wr_done), 0);
  endtask

  task automatic do_clr_one(input int m, input int n, input int slot);
    query_m = 4'(m);
    query_n = 4'(n);
    rd_slot = SB'(slot);
    clr_one = 1'b1;
    tick();
    clr_one = 1'b0;
    if (dims_ok(m, n)) mvalid[m][n][slot] = 1'b0;
  endtask

  task automatic bad_start(input int m, input int n);
    wr_start = 1'b1;
    wr_m = 4'(m);
    wr_n = 4'(n);
    tick();
    wr_start = 1'b0;
    check("wr_err_pulse", 32'(wr_err), 1);
    check("bad_start_busy", 32'(wr_busy), 0);
    tick();
    check("wr_err_clear", 32'(wr_err), 0);
  endtask

  initial begin
    int slot;
    bit hit_a, hit_b;
    logic [EW-1:0] d_a, d_b;

    rst = 1'b1;
    {wr_start, wr_abort, elem_valid, rd_req, clr_one, clr_all} = '0;
    {wr_m, wr_n, rd_m, rd_n, query_m, query_n} = '0;
    elem_in = '0;
    rd_slot = '0;
    rd_row = '0;
    rd_col = '0;
    model_clear_all();
    tick();
    tick();

    // Reset state
    check("rst_elem_ready", 32'(elem_ready), 0);
    check("rst_wr_busy", 32'(wr_busy), 0);
    check("rst_wr_done", 32'(wr_done), 0);
    check("rst_wr_err", 32'(wr_err), 0);
    check("rst_wr_slot", 32'(wr_slot), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_hit", 32'(rd_hit), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    query_check(2, 2);
    rst = 1'b0;
    tick();

    // 2x3 load of 1..6, element (1,2) is 6
    do_load(2, 3, -1, -2);
    read_check(2, 3, 0, 1, 2);
    check("rd_2x3_last_elem", 32'(rd_data), 6);
    query_check(2, 3);

    // Three 2x2 loads: slots 0, 1, then 0 again
    do_load(2, 2, -1, 'hA);
    do_load(2, 2, -1, 'hB);
    do_load(2, 2, -1, 'hC);
    read_check(2, 2, 0, 1, 1);
    read_check(2, 2, 1, 0, 0);
    query_check(2, 2);

    // Clear slot 0, D takes the free slot, E then evicts at the unmoved pointer
    do_clr_one(2, 2, 0);
    query_check(2, 2);
    do_load(2, 2, -1, 'hD);
    do_load(2, 2, -1, 'hE);
    read_check(2, 2, 0, 0, 1);
    read_check(2, 2, 1, 1, 0);

    // Back-to-back reads
    d_a = model_read(2, 3, 0, 0, 0, hit_a);
    d_b = model_read(2, 2, 1, 1, 1, hit_b);
    set_read(2, 3, 0, 0, 0);
    tick();
    set_read(2, 2, 1, 1, 1);
    check("b2b_hit_a", 32'(rd_hit), 32'(hit_a));
    check("b2b_data_a", 32'(rd_data), 32'(d_a));
    tick();
    rd_req = 1'b0;
    check("b2b_valid_b", 32'(rd_valid), 1);
    check("b2b_data_b", 32'(rd_data), 32'(d_b));

    // Abort a 3x3 load after 4 beats
    do_load(3, 3, 4, -1);
    query_check(3, 3);
    read_check(3, 3, 0, 0, 0);

    // Rejected starts and out-of-range row
    bad_start(0, 2);
    bad_start(2, 6);
    read_check(2, 2, 0, 2, 0);
    read_check(0, 2, 0, 0, 0);

    // wr_start during LOAD is ignored and raises no error
    slot = model_alloc(1, 2);
    mvalid[1][2][slot] = 1'b0;
    wr_start = 1'b1;
    wr_m = 4'd1;
    wr_n = 4'd2;
    tick();
    wr_m = 4'd0;
    elem_valid = 1'b1;
    elem_in = 8'h5A;
    mdata[1][2][slot][0] = 8'h5A;
    tick();
    wr_start = 1'b0;
    check("load_start_no_err", 32'(wr_err), 0);
    check("load_start_busy", 32'(wr_busy), 1);
    elem_in = 8'hA5;
    mdata[1][2][slot][1] = 8'hA5;
    tick();
    elem_valid = 1'b0;
    mvalid[1][2][slot] = 1'b1;
    check("load_start_done", 32'(wr_done), 1);
    read_check(1, 2, slot, 0, 1);

    // clr_all together with wr_start
    clr_all = 1'b1;
    wr_start = 1'b1;
    wr_m = 4'd2;
    wr_n = 4'd2;
    tick();
    clr_all = 1'b0;
    wr_start = 1'b0;
    model_clear_all();
    check("clr_all_busy", 32'(wr_busy), 0);
    check("clr_all_no_err", 32'(wr_err), 0);
    query_check(2, 2);
    query_check(2, 3);

    // rst mid-load
    do_load(2, 2, -1, -1);
    wr_start = 1'b1;
    wr_m = 4'd4;
    wr_n = 4'd4;
    tick();
    wr_start = 1'b0;
    elem_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      elem_in = EW'(k);
      tick();
    end
    elem_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async_ready", 32'(elem_ready), 0);
    check("rst_async_busy", 32'(wr_busy), 0);
    tick();
    rst = 1'b0;
    model_clear_all();
    tick();
    check("post_rst_ready", 32'(elem_ready), 0);
    query_check(4, 4);
    query_check(2, 2);

    // Randomized mix of loads, aborts, reads, clears and queries on small dimensions
    for (int it = 0; it < 60; it++) begin
      int op, m, n, ab;
      op = $urandom_range(0, 5);
      m = $urandom_range(1, 3);
      n = $urandom_range(1, 3);
      case (op)
        0, 1: begin
          ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, m * n - 1) : -1;
          do_load(m, n, ab, -1);
        end
        2, 3: read_check($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, SL - 1),
                         $urandom_range(0, 4), $urandom_range(0, 4));
        4: do_clr_one(m, n, $urandom_range(0, SL - 1));
        default: query_check($urandom_range(0, 6), $urandom_range(0, 6));
      endcase
    end

    // Sweep every slot of the small combos
    for (int m = 1; m <= 3; m++)
      for (int n = 1; n <= 3; n++)
        for (int s = 0; s < SL; s++)
          read_check(m, n, s, $urandom_range(0, m - 1), $urandom_range(0, n - 1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
